// File: rtl/mips_hazard_pkg.sv
// Shared encodings for the pipeline hazard controller and its MDU timer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_hazard_pkg;

  localparam int REG_ADDR_W = 5;

  // Reported hazard cause, listed in the order the controller resolves them.
  typedef enum logic [2:0] {
    HZ_NONE     = 3'd0,
    HZ_BRANCH   = 3'd1,
    HZ_LOAD_USE = 3'd2,
    HZ_MDU      = 3'd3,
    HZ_JUMP     = 3'd4
  } hz_cause_e;

  // MDU occupancy timer states.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_occupancy_timer.sv
// Tracks how long the multi-cycle multiply/divide unit stays occupied after an accept.
// Latency: busy rises the cycle after accept and stays high for exactly LATENCY cycles.
// Backpressure: none; accept is only honoured in RUN, so the caller must gate it with busy.
module mdu_occupancy_timer
  import mips_hazard_pkg::*;
#(
  parameter int LATENCY = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic accept,
  output logic busy
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  mdu_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // State and countdown registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Load on accept, count down while busy, drop back to RUN as the count reaches zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RUN: begin
        if (accept) begin
          state_nxt = ST_BUSY;
          cnt_nxt   = CNT_W'(LATENCY);
        end
      end
      ST_BUSY: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The MDU is occupied exactly while the timer is in BUSY.
  always_comb begin
    busy = (state == ST_BUSY);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: branch, load-use, MDU and jump hazards.
// Latency: hazard outputs are combinational (zero cycles); counters update on the next edge.
// Backpressure: stalls the front end by dropping pc_write/if_id_write and bubbling ID/EX.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W  = mips_hazard_pkg::REG_ADDR_W,
  parameter int MDU_LATENCY = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   ex_mem_read,
  input  logic [REG_ADDR_W-1:0]  ex_rt,
  input  logic                   id_is_jump,
  input  logic                   ex_branch_taken,
  input  logic                   id_mdu_start,
  input  logic                   id_mdu_read,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   mdu_busy,
  output logic [2:0]             hazard_cause,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  import mips_hazard_pkg::hz_cause_e;
  import mips_hazard_pkg::HZ_NONE;
  import mips_hazard_pkg::HZ_BRANCH;
  import mips_hazard_pkg::HZ_LOAD_USE;
  import mips_hazard_pkg::HZ_MDU;
  import mips_hazard_pkg::HZ_JUMP;

  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  hz_cause_e cause;
  logic      load_use;
  logic      mdu_conflict;
  logic      mdu_accept;

  // A load to r0 never creates a dependency, since r0 is hard-wired to zero.
  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((id_uses_rs && (ex_rt == id_rs)) || (id_uses_rt && (ex_rt == id_rt)));
  assign mdu_conflict = mdu_busy && (id_mdu_start || id_mdu_read);

  // Single-winner priority: a squashing branch beats every ID-stage hazard.
  always_comb begin
    cause       = HZ_NONE;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ex_branch_taken) begin
      cause       = HZ_BRANCH;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use || mdu_conflict) begin
      cause       = load_use ? HZ_LOAD_USE : HZ_MDU;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (id_is_jump) begin
      cause       = HZ_JUMP;
      if_id_flush = 1'b1;
    end
  end

  assign hazard_cause = cause;

  // The mult/div leaves ID only when nothing stalls or squashes it.
  assign mdu_accept = !reset && id_mdu_start && ((cause == HZ_NONE) || (cause == HZ_JUMP));

  mdu_occupancy_timer #(
    .LATENCY (MDU_LATENCY)
  ) u_mdu_timer (
    .clk    (clk),
    .reset  (reset),
    .accept (mdu_accept),
    .busy   (mdu_busy)
  );

  // Saturating count of stalled cycles; reset cycles are excluded.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!pc_write && (stall_cycles != STALL_MAX)) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed table, multi-cycle corner sequences, randomized vs reference model.
// Latency: checks combinational outputs mid-cycle, registered outputs after each edge.
// Backpressure: n/a.
module tb_pipeline_hazard_controller;

  localparam int L      = 4;
  localparam int CNT_W  = 4;
  localparam int SATMAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       reset;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       id_is_jump;
    logic       ex_branch_taken;
    logic       id_mdu_start;
    logic       id_mdu_read;
  } in_t;

  typedef struct packed {
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic [2:0] cause;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic             clk;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rs, id_uses_rt, ex_mem_read;
  logic             id_is_jump, ex_branch_taken, id_mdu_start, id_mdu_read;
  logic             pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_busy;
  logic [2:0]       hazard_cause;
  logic [CNT_W-1:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  // Reference model state: absolute cycle number and the last cycle the MDU is occupied.
  int m_cyc        = 0;
  int m_busy_until = -1;
  int m_stalls     = 0;
  bit m_known      = 0;

  // Values observed during the most recent step, for the hand-written sequences.
  exp_t last_out;
  logic last_busy;

  pipeline_hazard_controller #(
    .REG_ADDR_W  (5),
    .MDU_LATENCY (L),
    .STALL_CNT_W (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .id_is_jump      (id_is_jump),
    .ex_branch_taken (ex_branch_taken),
    .id_mdu_start    (id_mdu_start),
    .id_mdu_read     (id_mdu_read),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mdu_busy        (mdu_busy),
    .hazard_cause    (hazard_cause),
    .stall_cycles    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic in_t mk(input logic rst, input int rs, input int rt, input logic urs,
                             input logic urt, input logic mr, input int exrt, input logic j,
                             input logic b, input logic s, input logic r);
    in_t x;
    x.reset = rst; x.id_rs = 5'(rs); x.id_rt = 5'(rt);
    x.id_uses_rs = urs; x.id_uses_rt = urt; x.ex_mem_read = mr; x.ex_rt = 5'(exrt);
    x.id_is_jump = j; x.ex_branch_taken = b; x.id_mdu_start = s; x.id_mdu_read = r;
    return x;
  endfunction

  function automatic exp_t ex(input logic pw, input logic iw, input logic fi,
                              input logic fe, input int c);
    exp_t e;
    e.pc_write = pw; e.if_id_write = iw; e.if_id_flush = fi; e.id_ex_flush = fe;
    e.cause = 3'(c);
    return e;
  endfunction

  // Behavioural rules: pick the highest-priority hazard and emit its fixed control pattern.
  function automatic exp_t model_out(input in_t i, input bit busy);
    bit lu, mdu;
    if (i.reset) return ex(0, 0, 1, 1, 0);
    lu  = i.ex_mem_read && (i.ex_rt != 0) &&
          ((i.id_uses_rs && i.ex_rt == i.id_rs) || (i.id_uses_rt && i.ex_rt == i.id_rt));
    mdu = busy && (i.id_mdu_start || i.id_mdu_read);
    if (i.ex_branch_taken) return ex(1, 1, 1, 1, 1);
    if (lu)                return ex(0, 0, 0, 1, 2);
    if (mdu)               return ex(0, 0, 0, 1, 3);
    if (i.id_is_jump)      return ex(1, 1, 1, 0, 4);
    return ex(1, 1, 0, 0, 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, m_cyc, act, req);
    end
  endtask

  // One pipeline cycle: drive, check against the model, clock, advance the model.
  task automatic step(input in_t i);
    exp_t e;
    bit   busy, acc;
    reset = i.reset; id_rs = i.id_rs; id_rt = i.id_rt;
    id_uses_rs = i.id_uses_rs; id_uses_rt = i.id_uses_rt;
    ex_mem_read = i.ex_mem_read; ex_rt = i.ex_rt; id_is_jump = i.id_is_jump;
    ex_branch_taken = i.ex_branch_taken; id_mdu_start = i.id_mdu_start;
    id_mdu_read = i.id_mdu_read;
    #2;
    busy = (m_cyc <= m_busy_until);
    e = model_out(i, busy);
    last_out  = {pc_write, if_id_write, if_id_flush, id_ex_flush, hazard_cause};
    last_busy = mdu_busy;
    chk("model_outputs", 32'(last_out), 32'(e));
    if (m_known) begin
      chk("model_mdu_busy", 32'(mdu_busy), 32'(busy));
      chk("model_stall_cycles", 32'(stall_cycles), 32'(m_stalls));
    end
    acc = !i.reset && i.id_mdu_start && (e.cause == 0 || e.cause == 4);
    @(posedge clk);
    if (i.reset) begin
      m_busy_until = -1;
      m_stalls     = 0;
      m_known      = 1;
    end else begin
      if (acc) m_busy_until = m_cyc + L;
      if (!e.pc_write && m_stalls < SATMAX) m_stalls++;
    end
    m_cyc++;
    @(negedge clk);
  endtask

  vec_t tbl[12];
  in_t  idle, rst, lu8;
  logic [5:0] win;
  logic [4:0] pcs;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu8  = mk(0, 8, 0, 1, 0, 1, 8, 0, 0, 0, 0);
    reset = 1'b1; id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
    ex_mem_read = 0; ex_rt = '0; id_is_jump = 0; ex_branch_taken = 0;
    id_mdu_start = 0; id_mdu_read = 0;

    tbl[0]  = '{mk(0, 8, 0, 1, 0, 1, 8, 0, 0, 0, 0), ex(0, 0, 0, 1, 2)};
    tbl[1]  = '{mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), ex(1, 1, 0, 0, 0)};
    tbl[2]  = '{mk(0, 3, 9, 0, 1, 1, 9, 0, 0, 0, 0), ex(0, 0, 0, 1, 2)};
    tbl[3]  = '{mk(0, 3, 9, 0, 0, 1, 9, 0, 0, 0, 0), ex(1, 1, 0, 0, 0)};
    tbl[4]  = '{mk(0, 8, 0, 1, 0, 0, 8, 0, 0, 0, 0), ex(1, 1, 0, 0, 0)};
    tbl[5]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), ex(1, 1, 1, 0, 4)};
    tbl[6]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), ex(1, 1, 1, 1, 1)};
    tbl[7]  = '{mk(0, 8, 0, 1, 0, 1, 8, 0, 1, 0, 0), ex(1, 1, 1, 1, 1)};
    tbl[8]  = '{mk(0, 8, 0, 1, 0, 1, 8, 1, 0, 0, 0), ex(0, 0, 0, 1, 2)};
    tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ex(1, 1, 0, 0, 0)};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(1, 1, 0, 0, 0)};
    tbl[11] = '{mk(0, 7, 6, 0, 1, 1, 7, 0, 0, 0, 0), ex(1, 1, 0, 0, 0)};

    @(negedge clk);
    // Reset: forced outputs, then cleared registered state.
    step(rst);
    chk("reset_outputs", 32'(last_out), 32'(ex(0, 0, 1, 1, 0)));
    step(rst);
    chk("reset_busy", 32'(mdu_busy), 32'd0);
    chk("reset_stalls", 32'(stall_cycles), 32'd0);

    // Directed vector table, MDU idle throughout.
    for (int k = 0; k < 12; k++) begin
      step(tbl[k].i);
      chk($sformatf("table_%0d", k), 32'(last_out), 32'(tbl[k].e));
    end

    // Load-use lasts one cycle and counts once.
    step(rst);
    step(lu8);
    chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);
    step(mk(0, 8, 0, 1, 0, 0, 8, 0, 0, 0, 0));
    chk("lu_release", 32'(last_out.pc_write), 32'd1);
    chk("lu_stall_hold", 32'(stall_cycles), 32'd1);

    // MDU accept followed by mflo held in ID: four stalled cycles, advance on the fifth.
    step(rst);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    chk("mdu_accept_nostall", 32'(last_out), 32'(ex(1, 1, 0, 0, 0)));
    for (int k = 0; k < 5; k++) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      win[k] = last_busy;
      pcs[k] = last_out.pc_write;
    end
    chk("mdu_busy_window", 32'(win[4:0]), 32'b01111);
    chk("mdu_read_stall", 32'(pcs), 32'b10000);
    chk("mdu_stall_cnt", 32'(stall_cycles), 32'd4);

    // Branch beats load-use and MDU during BUSY, neither accepting nor aborting the timer.
    step(rst);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(idle); win[0] = last_busy;
    step(mk(0, 8, 0, 1, 0, 1, 8, 0, 1, 1, 0)); win[1] = last_busy;
    chk("prio_branch", 32'(last_out), 32'(ex(1, 1, 1, 1, 1)));
    for (int k = 2; k < 6; k++) begin
      step(idle);
      win[k] = last_busy;
    end
    chk("prio_timer_window", 32'(win), 32'b001111);

    // Reset during BUSY aborts the timer; a fresh accept gets a full window.
    step(rst);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("rst_busy_outputs", 32'(last_out), 32'(ex(0, 0, 1, 1, 0)));
    chk("rst_busy_cleared", 32'(mdu_busy), 32'd0);
    chk("rst_busy_stalls", 32'(stall_cycles), 32'd0);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 6; k++) begin
      step(idle);
      win[k] = last_busy;
    end
    chk("rst_new_window", 32'(win), 32'b001111);

    // Continuous stall for 20 cycles saturates the counter.
    step(rst);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 20; k++) step(mk(0, 8, 0, 1, 0, 1, 8, 0, 0, 0, 1));
    chk("stall_saturate", 32'(stall_cycles), 32'(SATMAX));

    // Randomized traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      in_t r;
      r.reset           = ($urandom_range(0, 39) == 0);
      r.id_rs           = 5'($urandom_range(0, 3));
      r.id_rt           = 5'($urandom_range(0, 3));
      r.id_uses_rs      = 1'($urandom_range(0, 1));
      r.id_uses_rt      = 1'($urandom_range(0, 1));
      r.ex_mem_read     = ($urandom_range(0, 2) == 0);
      r.ex_rt           = 5'($urandom_range(0, 3));
      r.id_is_jump      = ($urandom_range(0, 5) == 0);
      r.ex_branch_taken = ($urandom_range(0, 4) == 0);
      r.id_mdu_start    = ($urandom_range(0, 3) == 0);
      r.id_mdu_read     = ($urandom_range(0, 3) == 0);
      step(r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
